// File: rtl/common_pkg.sv
// Shared types and constants for the status flag unit: condition modes,
// error-bit positions and the flag-condition evaluator.
package common_pkg;

  typedef enum logic {
    COND_ANY = 1'b0,
    COND_ALL = 1'b1
  } cond_mode_e;

  localparam int ERR_OVF    = 0;
  localparam int ERR_UNF    = 1;
  localparam int ERR_COL    = 2;
  localparam int ERR_W      = 3;
  localparam int MAX_FLAG_W = 16;

  // Operands are zero-extended to MAX_FLAG_W, so unused upper bits never
  // affect either mode; an empty select is "all of nothing" and passes COND_ALL.
  function automatic logic cond_eval(input logic [MAX_FLAG_W-1:0] flags,
                                     input logic [MAX_FLAG_W-1:0] sel,
                                     input cond_mode_e            mode);
    logic [MAX_FLAG_W-1:0] hit;
    hit = flags & sel;
    return (mode == COND_ALL) ? (hit == sel) : (|hit);
  endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO save-stack for flag snapshots. The caller only asserts push_in when
// not full and pop_in when not empty, and never both together.
module flag_stack #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             reset_n_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] top_out,
  output logic [CNT_W-1:0] count_out
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [2**IDX_W];
  logic [CNT_W-1:0] count_q;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;

  // Modular index arithmetic: count-1 is always below 2**IDX_W when a pop is legal.
  assign wr_idx = count_q[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);

  // NOTE: storage has no reset; entries at or above count are never read,
  // so clearing them would only cost reset fan-out.
  always_ff @(posedge clk_in) begin
    if (push_in) mem[wr_idx] <= data_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)  count_q <= '0;
    else if (push_in) count_q <= count_q + CNT_W'(1);
    else if (pop_in)  count_q <= count_q - CNT_W'(1);
  end

  assign top_out   = mem[rd_idx];
  assign count_out = count_q;

endmodule

// File: rtl/status_flag_unit.sv
// Status flag register with masked writes, a latched flag condition, a
// save/restore stack and sticky error reporting for illegal stack use.
module status_flag_unit
  import common_pkg::*;
#(
  parameter  int FLAG_W      = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk_in,
  input  logic              reset_n_in,
  input  logic [FLAG_W-1:0] status_in,
  input  logic [FLAG_W-1:0] status_mask_in,
  input  logic              status_write_en_in,
  input  logic [FLAG_W-1:0] cond_sel_in,
  input  logic              cond_mode_in,
  input  logic              cond_invert_in,
  input  logic              cond_en_in,
  input  logic              push_in,
  input  logic              pop_in,
  input  logic              err_clr_in,
  output logic [FLAG_W-1:0] status_out,
  output logic              cond_out,
  output logic [CNT_W-1:0]  stack_count_out,
  output logic              stack_full_out,
  output logic              stack_empty_out,
  output logic [ERR_W-1:0]  err_out
);

  logic [FLAG_W-1:0] flags_q;
  logic [FLAG_W-1:0] write_val;
  logic [FLAG_W-1:0] stack_top;
  logic              cond_q;
  logic              cond_raw;
  logic [ERR_W-1:0]  err_q;
  logic [ERR_W-1:0]  err_new;
  logic              do_push;
  logic              do_pop;

  assign stack_full_out  = (stack_count_out == CNT_W'(STACK_DEPTH));
  assign stack_empty_out = (stack_count_out == '0);

  assign do_push   = push_in & ~pop_in & ~stack_full_out;
  assign do_pop    = pop_in & ~push_in & ~stack_empty_out;
  assign write_val = (flags_q & ~status_mask_in) | (status_in & status_mask_in);
  assign cond_raw  = cond_eval(MAX_FLAG_W'(flags_q), MAX_FLAG_W'(cond_sel_in),
                               cond_mode_e'(cond_mode_in));

  // NOTE: every bit gets a default before the conditional updates so this
  // block stays purely combinational with no inferred latch.
  always_comb begin
    err_new          = '0;
    err_new[ERR_OVF] = push_in & ~pop_in & stack_full_out;
    err_new[ERR_UNF] = pop_in & ~push_in & stack_empty_out;
    err_new[ERR_COL] = push_in & pop_in;
  end

  flag_stack #(
    .WIDTH (FLAG_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk_in     (clk_in),
    .reset_n_in (reset_n_in),
    .push_in    (do_push),
    .pop_in     (do_pop),
    .data_in    (flags_q),
    .top_out    (stack_top),
    .count_out  (stack_count_out)
  );

  // A successful pop restores the snapshot and discards any same-cycle write;
  // a new error in a clear cycle is OR-ed in after the clear so it survives.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      flags_q <= '0;
      cond_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      if (do_pop)                  flags_q <= stack_top;
      else if (status_write_en_in) flags_q <= write_val;
      if (cond_en_in)              cond_q  <= cond_raw ^ cond_invert_in;
      err_q <= (err_clr_in ? '0 : err_q) | err_new;
    end
  end

  assign status_out = flags_q;
  assign cond_out   = cond_q;
  assign err_out    = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed and randomized checks of status_flag_unit against a queue-based
// behavioural model of the flag register, condition latch and save-stack.
module tb_status_flag_unit;

  localparam int FLAG_W = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;

  logic              clk_in = 1'b0;
  logic              reset_n_in;
  logic [FLAG_W-1:0] status_in;
  logic [FLAG_W-1:0] status_mask_in;
  logic              status_write_en_in;
  logic [FLAG_W-1:0] cond_sel_in;
  logic              cond_mode_in;
  logic              cond_invert_in;
  logic              cond_en_in;
  logic              push_in;
  logic              pop_in;
  logic              err_clr_in;
  logic [FLAG_W-1:0] status_out;
  logic              cond_out;
  logic [CNT_W-1:0]  stack_count_out;
  logic              stack_full_out;
  logic              stack_empty_out;
  logic [2:0]        err_out;

  status_flag_unit #(.FLAG_W(FLAG_W), .STACK_DEPTH(DEPTH)) dut (
    .clk_in             (clk_in),
    .reset_n_in         (reset_n_in),
    .status_in          (status_in),
    .status_mask_in     (status_mask_in),
    .status_write_en_in (status_write_en_in),
    .cond_sel_in        (cond_sel_in),
    .cond_mode_in       (cond_mode_in),
    .cond_invert_in     (cond_invert_in),
    .cond_en_in         (cond_en_in),
    .push_in            (push_in),
    .pop_in             (pop_in),
    .err_clr_in         (err_clr_in),
    .status_out         (status_out),
    .cond_out           (cond_out),
    .stack_count_out    (stack_count_out),
    .stack_full_out     (stack_full_out),
    .stack_empty_out    (stack_empty_out),
    .err_out            (err_out)
  );

  always #5 clk_in = ~clk_in;

  logic [FLAG_W-1:0] m_flags;
  logic [FLAG_W-1:0] m_stack[$];
  logic              m_cond;
  logic [2:0]        m_err;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_stack.delete();
    m_cond  = 1'b0;
    m_err   = '0;
  endtask

  // One clock of the architectural behaviour, from the current inputs.
  task automatic model_step();
    logic [FLAG_W-1:0] hit;
    logic [2:0]        e;
    bit                do_write;
    if (cond_en_in) begin
      hit    = m_flags & cond_sel_in;
      m_cond = (cond_mode_in ? (hit == cond_sel_in) : (hit != 0)) ^ cond_invert_in;
    end
    e        = '0;
    do_write = status_write_en_in;
    if (push_in && pop_in) e[2] = 1'b1;
    else if (push_in) begin
      if (m_stack.size() == DEPTH) e[0] = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (pop_in) begin
      if (m_stack.size() == 0) e[1] = 1'b1;
      else begin
        m_flags  = m_stack.pop_back();
        do_write = 1'b0;
      end
    end
    if (do_write) m_flags = (m_flags & ~status_mask_in) | (status_in & status_mask_in);
    m_err = (err_clr_in ? 3'b000 : m_err) | e;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".status"}, 16'(status_out), 16'(m_flags));
    check({tag, ".cond"},   16'(cond_out), 16'(m_cond));
    check({tag, ".count"},  16'(stack_count_out), 16'(m_stack.size()));
    check({tag, ".full"},   16'(stack_full_out), 16'(m_stack.size() == DEPTH));
    check({tag, ".empty"},  16'(stack_empty_out), 16'(m_stack.size() == 0));
    check({tag, ".err"},    16'(err_out), 16'(m_err));
  endtask

  task automatic tick(input string tag);
    @(posedge clk_in);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic idle();
    status_in          = '0;
    status_mask_in     = '0;
    status_write_en_in = 1'b0;
    cond_sel_in        = '0;
    cond_mode_in       = 1'b0;
    cond_invert_in     = 1'b0;
    cond_en_in         = 1'b0;
    push_in            = 1'b0;
    pop_in             = 1'b0;
    err_clr_in         = 1'b0;
  endtask

  task automatic write(input logic [FLAG_W-1:0] val, input logic [FLAG_W-1:0] mask);
    status_in          = val;
    status_mask_in     = mask;
    status_write_en_in = 1'b1;
  endtask

  task automatic cond(input logic mode, input logic inv, input logic [FLAG_W-1:0] sel);
    cond_mode_in   = mode;
    cond_invert_in = inv;
    cond_sel_in    = sel;
    cond_en_in     = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".status"}, 16'(status_out), 16'h0);
    check({tag, ".cond"},   16'(cond_out), 16'h0);
    check({tag, ".count"},  16'(stack_count_out), 16'h0);
    check({tag, ".empty"},  16'(stack_empty_out), 16'h1);
    check({tag, ".full"},   16'(stack_full_out), 16'h0);
    check({tag, ".err"},    16'(err_out), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset_n_in = 1'b0;
    model_reset();
    #12;
    check_reset_values("por");
    #1 reset_n_in = 1'b1;

    // Masked writes
    idle(); write(4'b1111, 4'b0101); tick("wr1");
    check("wr1.val", 16'(status_out), 16'h5);
    idle(); write(4'b0000, 4'b0001); tick("wr2");
    check("wr2.val", 16'(status_out), 16'h4);

    // Condition modes on flags 0110, each visible one cycle after enable
    idle(); write(4'b0110, 4'b1111); tick("setf");
    idle(); cond(1'b0, 1'b0, 4'b0011); tick("c_any");
    check("c_any.val", 16'(cond_out), 16'h1);
    idle(); cond(1'b1, 1'b0, 4'b0011); tick("c_all");
    check("c_all.val", 16'(cond_out), 16'h0);
    idle(); cond(1'b1, 1'b1, 4'b0011); tick("c_inv");
    check("c_inv.val", 16'(cond_out), 16'h1);
    idle(); cond(1'b1, 1'b0, 4'b0000); tick("c_sel0");
    check("c_sel0.val", 16'(cond_out), 16'h1);
    idle(); cond_mode_in = 1'b0; cond_sel_in = 4'b0000; tick("c_hold");
    check("c_hold.val", 16'(cond_out), 16'h1);

    // Fill the stack with 0001..0100 (push saves pre-write flags), then overflow
    idle(); write(4'b0001, 4'b1111); tick("f0");
    idle(); push_in = 1'b1; write(4'b0010, 4'b1111); tick("p1");
    idle(); push_in = 1'b1; write(4'b0011, 4'b1111); tick("p2");
    idle(); push_in = 1'b1; write(4'b0100, 4'b1111); tick("p3");
    idle(); push_in = 1'b1; tick("p4");
    check("p4.count", 16'(stack_count_out), 16'h4);
    idle(); push_in = 1'b1; tick("p5_ovf");
    check("ovf.count", 16'(stack_count_out), 16'h4);
    check("ovf.full", 16'(stack_full_out), 16'h1);
    check("ovf.err", 16'(err_out), 16'h1);

    // Pops restore in LIFO order; first pop's same-cycle write is discarded
    idle(); pop_in = 1'b1; write(4'b1111, 4'b1111); tick("pop1");
    check("pop1.val", 16'(status_out), 16'h4);
    idle(); pop_in = 1'b1; tick("pop2");
    check("pop2.val", 16'(status_out), 16'h3);
    idle(); pop_in = 1'b1; tick("pop3");
    check("pop3.val", 16'(status_out), 16'h2);
    idle(); pop_in = 1'b1; tick("pop4");
    check("pop4.val", 16'(status_out), 16'h1);
    check("pop4.empty", 16'(stack_empty_out), 16'h1);

    // Underflow, sticky clear, and new error winning over clear
    idle(); err_clr_in = 1'b1; tick("clr1");
    check("clr1.err", 16'(err_out), 16'h0);
    idle(); pop_in = 1'b1; write(4'b1010, 4'b1111); tick("unf");
    check("unf.val", 16'(status_out), 16'ha);
    check("unf.err", 16'(err_out), 16'h2);
    idle(); err_clr_in = 1'b1; tick("clr2");
    check("clr2.err", 16'(err_out), 16'h0);
    idle(); err_clr_in = 1'b1; pop_in = 1'b1; tick("clr_win");
    check("clr_win.err", 16'(err_out), 16'h2);
    idle(); err_clr_in = 1'b1; tick("clr3");

    // Push+pop collision; condition sees pre-write flags 1010
    idle(); push_in = 1'b1; tick("pc_pre");
    idle(); push_in = 1'b1; pop_in = 1'b1; write(4'b1100, 4'b1111);
    cond(1'b1, 1'b0, 4'b1010); tick("col");
    check("col.count", 16'(stack_count_out), 16'h1);
    check("col.val", 16'(status_out), 16'hc);
    check("col.err", 16'(err_out), 16'h4);
    check("col.cond", 16'(cond_out), 16'h1);
    idle(); push_in = 1'b1; tick("pc_post");
    check("pc_post.count", 16'(stack_count_out), 16'h2);

    // Asynchronous reset between edges
    #2 reset_n_in = 1'b0;
    model_reset();
    #1 check_reset_values("arst");
    #2 reset_n_in = 1'b1;

    // Randomized traffic against the model, with one more mid-cycle reset
    for (int i = 0; i < 400; i++) begin
      status_in          = 4'($urandom);
      status_mask_in     = 4'($urandom);
      status_write_en_in = 1'($urandom);
      cond_sel_in        = 4'($urandom);
      cond_mode_in       = 1'($urandom);
      cond_invert_in     = 1'($urandom);
      cond_en_in         = 1'($urandom);
      push_in            = ($urandom_range(0, 2) == 0);
      pop_in             = ($urandom_range(0, 2) == 0);
      err_clr_in         = ($urandom_range(0, 7) == 0);
      tick("rand");
      if (i == 200) begin
        #2 reset_n_in = 1'b0;
        model_reset();
        #1 check_model("rand_rst");
        #2 reset_n_in = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
